// File: rtl/tt_um_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor tile: operand width,
// FSM state encoding and the pin positions of control and status bits.
package tt_um_serial_subtractor_pkg;

  localparam int SUB_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // uio_in bit positions
  localparam int PIN_START = 0;
  localparam int PIN_ACK   = 1;

  // uo_out bit positions
  localparam int PIN_BORROW = 4;
  localparam int PIN_BUSY   = 5;
  localparam int PIN_DONE   = 6;

endpackage

// File: rtl/tt_um_serial_subtractor_fs_cell.sv
// Combinational full subtractor: d = a - b - bin, bout set when the
// subtraction of this bit position needs to borrow from the next one.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign d     = w_axb ^ bin;
  assign bout  = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial subtractor: A - B computed LSB first, one bit per clock, through
// a single full-subtractor cell and a borrow flip-flop. The visible result
// only updates when an operation completes, never with partial bits.
module tt_um_serial_subtractor
  import tt_um_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  input  logic       ena,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             r_state;
  state_t             w_state_n;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [WIDTH-1:0]   r_sd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_bw;
  logic [WIDTH-1:0]   r_result;
  logic               r_bout;
  logic               r_busy;
  logic               r_done;

  logic               w_start;
  logic               w_ack;
  logic               w_load;
  logic               w_shift;
  logic               w_last;
  logic               w_d;
  logic               w_bw_n;
  logic [WIDTH-1:0]   w_sd_n;
  logic [7:0]         w_uo_out;
  logic               w_unused;

  assign w_start = uio_in[PIN_START];
  assign w_ack   = uio_in[PIN_ACK];

  fs_cell u_fs_cell (
    .a    (r_sa[0]),
    .b    (r_sb[0]),
    .bin  (r_bw),
    .d    (w_d),
    .bout (w_bw_n)
  );

  // Difference bits enter at the MSB so the LSB-first stream lands in place.
  assign w_sd_n = {w_d, r_sd[WIDTH-1:1]};

  // Next-state decode; start takes priority over ack in DONE.
  always_comb begin
    w_state_n = r_state;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    w_last    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_n = SHIFT;
          w_load    = 1'b1;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_last    = 1'b1;
          w_state_n = DONE;
        end
      end
      DONE: begin
        if (w_start) begin
          w_state_n = SHIFT;
          w_load    = 1'b1;
        end else if (w_ack) begin
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // State register; status flags are registered copies of the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_busy  <= (r_state == SHIFT);
      r_done  <= (r_state == DONE);
    end
  end

  // Operand load, serial shift and result capture on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_sd     <= '0;
      r_cnt    <= '0;
      r_bw     <= 1'b0;
      r_result <= '0;
      r_bout   <= 1'b0;
    end else if (w_load) begin
      r_sa  <= ui_in[WIDTH-1:0];
      r_sb  <= ui_in[2*WIDTH-1:WIDTH];
      r_sd  <= '0;
      r_cnt <= '0;
      r_bw  <= 1'b0;
    end else if (w_shift) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_sd  <= w_sd_n;
      r_bw  <= w_bw_n;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_result <= w_sd_n;
        r_bout   <= w_bw_n;
      end
    end
  end

  // Pack result and status onto the dedicated outputs.
  always_comb begin
    w_uo_out             = '0;
    w_uo_out[WIDTH-1:0]  = r_result;
    w_uo_out[PIN_BORROW] = r_bout;
    w_uo_out[PIN_BUSY]   = r_busy;
    w_uo_out[PIN_DONE]   = r_done;
  end

  assign uo_out   = w_uo_out;
  assign uio_out  = 8'h00;
  assign uio_oe   = 8'h00;
  assign w_unused = &{1'b0, ena, uio_in[7:2]};

endmodule
